vec_exec_pipe: RTL and testbench

Parametrised successor to the 4-lane matrix execute datapath. It holds NREGS matrix registers, each LANES rows of ELEMS elements of ELEM_W bits. Instructions are accepted over a valid/ready handshake and run through a two-stage pipeline (read/forward, execute/writeback), with a loop counter and a back-pressured matrix store port. It sits between the instruction sequencer (fetch/hazard logic) and data memory, and replaces the fixed four-ALU, four-register-file arrangement.

---
 rtl/vec_exec_pipe.sv | 272 +++++++++++++++++++++++++++
 tb/tb_vec_exec_pipe.sv | 330 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/vec_exec_pipe.sv
// vec_exec_pipe
// -------------
// Two-stage matrix execute pipeline with NREGS matrix registers, each made of
// LANES rows of ELEMS elements, ELEM_W bits per element. The first stage (S1)
// reads operands and forwards the S2 result. The second stage (S2) registers
// the ALU result, which is written to the register file on the following edge.
// The block also holds a saturating loop counter and a back-pressured matrix
// store port.
//
// Matrix layout: lane (row) 0 is in the MSBs. Within each row, element 0 is in
// the MSBs.
//
// Ports:
//   clk        rising-edge clock
//   rst        asynchronous reset, active low
//   in_valid   instruction offered
//   in_ready   instruction accepted on in_valid && in_ready at the clock edge
//   in_op      opcode
//   in_rd      destination register
//   in_rs1     source register 1
//   in_rs2     source register 2
//   in_col     ROTL rotate amount
//   in_imm     LDCNT load value
//   in_data    LOAD matrix
//   out_valid  store data valid
//   out_ready  store data consumed on out_valid && out_ready at the clock edge
//   out_matrix stored matrix
//   cnt_zero   registered flag, set when the counter is zero
//   busy       set when either pipeline stage holds an instruction
module vec_exec_pipe #(
    parameter int LANES  = 4,
    parameter int ELEMS  = 4,
    parameter int ELEM_W = 8,
    parameter int NREGS  = 4,
    parameter int CNT_W  = 16,
    localparam int ROW_W = ELEMS * ELEM_W,
    localparam int MAT_W = LANES * ROW_W,
    localparam int RA_W  = (NREGS > 1) ? $clog2(NREGS) : 1,
    localparam int COL_W = (ELEMS > 1) ? $clog2(ELEMS) : 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0]       in_op,
    input  logic [RA_W-1:0]  in_rd,
    input  logic [RA_W-1:0]  in_rs1,
    input  logic [RA_W-1:0]  in_rs2,
    input  logic [COL_W-1:0] in_col,
    input  logic [CNT_W-1:0] in_imm,
    input  logic [MAT_W-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [MAT_W-1:0] out_matrix,
    output logic             cnt_zero,
    output logic             busy
);

    typedef enum logic [3:0] {
        OP_NOP    = 4'd0,
        OP_XOR    = 4'd1,
        OP_ADD    = 4'd2,
        OP_SUB    = 4'd3,
        OP_ROTL   = 4'd4,
        OP_TRANS  = 4'd5,
        OP_LDCNT  = 4'd6,
        OP_DECCNT = 4'd7,
        OP_STORE  = 4'd8,
        OP_LOAD   = 4'd9
    } op_t;

    // Bit offset of element (row, col) inside a packed matrix.
    function automatic int elem_lsb(int row, int col);
        return MAT_W - (row * ELEMS + col + 1) * ELEM_W;
    endfunction

    logic             s1_valid;
    logic [3:0]       s1_op;
    logic [RA_W-1:0]  s1_rd;
    logic [RA_W-1:0]  s1_rs1;
    logic [RA_W-1:0]  s1_rs2;
    logic [COL_W-1:0] s1_col;
    logic [CNT_W-1:0] s1_imm;
    logic [MAT_W-1:0] s1_data;

    logic             s2_valid;
    logic             s2_wr;
    logic [RA_W-1:0]  s2_rd;
    logic [MAT_W-1:0] s2_result;

    logic [MAT_W-1:0] regs [NREGS];
    logic [CNT_W-1:0] count;

    logic [MAT_W-1:0] op_a;
    logic [MAT_W-1:0] op_b;
    logic [MAT_W-1:0] alu_result;
    logic [MAT_W-1:0] trans_result;
    logic             s1_writes;
    logic             stall;
    logic             s1_fire;
    logic [CNT_W-1:0] cnt_next;
    logic             cnt_load;

    // A STORE cannot leave S1 while the previous store is still waiting on the
    // output port. Only that case holds the front of the pipe.
    assign stall    = out_valid && !out_ready && s1_valid && (s1_op == OP_STORE);
    assign in_ready = !stall;
    assign s1_fire  = s1_valid && !stall;
    assign busy     = s1_valid | s2_valid;

    // Read the operands. S2 is always the youngest pending write, so its
    // result takes priority over the register file.
    // Register indices at or above NREGS read as zero.
    always_comb begin
        op_a = '0;
        op_b = '0;
        for (int r = 0; r < NREGS; r++) begin
            if (s1_rs1 == RA_W'(r)) op_a = regs[r];
            if (s1_rs2 == RA_W'(r)) op_b = regs[r];
        end
        if (s2_valid && s2_wr && (s2_rd == s1_rs1)) op_a = s2_result;
        if (s2_valid && s2_wr && (s2_rd == s1_rs2)) op_b = s2_result;
    end

    // A true transpose only exists for square matrices.
    // Otherwise TRANS passes rs1 through unchanged.
    if (LANES == ELEMS) begin : g_trans
        always_comb begin
            trans_result = '0;
            for (int i = 0; i < LANES; i++)
                for (int j = 0; j < ELEMS; j++)
                    trans_result[elem_lsb(i, j) +: ELEM_W] = op_a[elem_lsb(j, i) +: ELEM_W];
        end
    end else begin : g_copy
        assign trans_result = op_a;
    end

    // Element-wise ALU.
    // Element order does not matter for ADD and SUB, so they walk the flat
    // element index.
    always_comb begin
        alu_result = '0;
        s1_writes  = 1'b0;
        case (s1_op)
            OP_XOR: begin
                alu_result = op_a ^ op_b;
                s1_writes  = 1'b1;
            end
            OP_ADD: begin
                for (int e = 0; e < LANES * ELEMS; e++)
                    alu_result[e*ELEM_W +: ELEM_W] = op_a[e*ELEM_W +: ELEM_W] + op_b[e*ELEM_W +: ELEM_W];
                s1_writes = 1'b1;
            end
            OP_SUB: begin
                for (int e = 0; e < LANES * ELEMS; e++)
                    alu_result[e*ELEM_W +: ELEM_W] = op_a[e*ELEM_W +: ELEM_W] - op_b[e*ELEM_W +: ELEM_W];
                s1_writes = 1'b1;
            end
            OP_ROTL: begin
                for (int i = 0; i < LANES; i++)
                    for (int j = 0; j < ELEMS; j++)
                        alu_result[elem_lsb(i, j) +: ELEM_W] =
                            op_a[elem_lsb(i, (j + int'(s1_col)) % ELEMS) +: ELEM_W];
                s1_writes = 1'b1;
            end
            OP_TRANS: begin
                alu_result = trans_result;
                s1_writes  = 1'b1;
            end
            OP_LOAD: begin
                alu_result = s1_data;
                s1_writes  = 1'b1;
            end
            default: begin
                alu_result = '0;
                s1_writes  = 1'b0;
            end
        endcase
    end

    // Next counter value: a load, or a decrement that saturates at zero.
    always_comb begin
        cnt_next = count;
        cnt_load = 1'b0;
        if (s1_fire && (s1_op == OP_LDCNT)) begin
            cnt_next = s1_imm;
            cnt_load = 1'b1;
        end else if (s1_fire && (s1_op == OP_DECCNT)) begin
            cnt_next = (count == '0) ? '0 : count - CNT_W'(1);
            cnt_load = 1'b1;
        end
    end

    // Stage 1 register. It holds its contents while stalled.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            s1_valid <= 1'b0;
            s1_op    <= '0;
            s1_rd    <= '0;
            s1_rs1   <= '0;
            s1_rs2   <= '0;
            s1_col   <= '0;
            s1_imm   <= '0;
            s1_data  <= '0;
        end else if (!stall) begin
            s1_valid <= in_valid;
            if (in_valid) begin
                s1_op   <= in_op;
                s1_rd   <= in_rd;
                s1_rs1  <= in_rs1;
                s1_rs2  <= in_rs2;
                s1_col  <= in_col;
                s1_imm  <= in_imm;
                s1_data <= in_data;
            end
        end
    end

    // Stage 2 register. A stall sends a bubble into S2 while the older
    // instruction already in S2 still retires.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            s2_valid  <= 1'b0;
            s2_wr     <= 1'b0;
            s2_rd     <= '0;
            s2_result <= '0;
        end else if (stall) begin
            s2_valid <= 1'b0;
        end else begin
            s2_valid  <= s1_valid;
            s2_wr     <= s1_valid && s1_writes;
            s2_rd     <= s1_rd;
            s2_result <= alu_result;
        end
    end

    // Register file write-back from S2.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int r = 0; r < NREGS; r++) regs[r] <= '0;
        end else begin
            for (int r = 0; r < NREGS; r++)
                if (s2_valid && s2_wr && (s2_rd == RA_W'(r))) regs[r] <= s2_result;
        end
    end

    // Loop counter and its registered zero flag.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count    <= '0;
            cnt_zero <= 1'b1;
        end else if (cnt_load) begin
            count    <= cnt_next;
            cnt_zero <= (cnt_next == '0);
        end
    end

    // Store port. A STORE arriving on the same edge as a handshake replaces
    // the data without dropping out_valid.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            out_valid  <= 1'b0;
            out_matrix <= '0;
        end else if (s1_fire && (s1_op == OP_STORE)) begin
            out_valid  <= 1'b1;
            out_matrix <= op_a;
        end else if (out_valid && out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_vec_exec_pipe.sv
// tb_vec_exec_pipe
// ----------------
// Self-checking bench for vec_exec_pipe at the default geometry:
// 4x4 matrices of 8-bit elements, four registers, 16-bit counter.
// A reference model applies each accepted instruction in program order to an
// architectural register array. Its results are compared with the store port,
// cnt_zero and the handshake signals.
module tb_vec_exec_pipe;

    localparam int LANES  = 4;
    localparam int ELEMS  = 4;
    localparam int ELEM_W = 8;
    localparam int NREGS  = 4;
    localparam int CNT_W  = 16;
    localparam int MAT_W  = LANES * ELEMS * ELEM_W;
    localparam int RA_W   = 2;
    localparam int COL_W  = 2;

    localparam logic [3:0] XOR_OP = 4'd1, ADD_OP = 4'd2, SUB_OP = 4'd3, ROTL_OP = 4'd4,
                           TRANS_OP = 4'd5, LDCNT_OP = 4'd6, DEC_OP = 4'd7,
                           STORE_OP = 4'd8, LOAD_OP = 4'd9;

    logic             clk;
    logic             rst;
    logic             in_valid;
    logic             in_ready;
    logic [3:0]       in_op;
    logic [RA_W-1:0]  in_rd;
    logic [RA_W-1:0]  in_rs1;
    logic [RA_W-1:0]  in_rs2;
    logic [COL_W-1:0] in_col;
    logic [CNT_W-1:0] in_imm;
    logic [MAT_W-1:0] in_data;
    logic             out_valid;
    logic             out_ready;
    logic [MAT_W-1:0] out_matrix;
    logic             cnt_zero;
    logic             busy;

    vec_exec_pipe #(
        .LANES (LANES),
        .ELEMS (ELEMS),
        .ELEM_W(ELEM_W),
        .NREGS (NREGS),
        .CNT_W (CNT_W)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_op     (in_op),
        .in_rd     (in_rd),
        .in_rs1    (in_rs1),
        .in_rs2    (in_rs2),
        .in_col    (in_col),
        .in_imm    (in_imm),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_matrix(out_matrix),
        .cnt_zero  (cnt_zero),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int testCount = 0;
    int failCount = 0;

    // Architectural model state
    logic [MAT_W-1:0] mreg [NREGS];
    int               mcnt;
    bit               expStore;
    logic [MAT_W-1:0] expStoreData;

    function automatic logic [7:0] getEl(logic [MAT_W-1:0] m, int row, int col);
        return m[MAT_W - 1 - 8 * (ELEMS * row + col) -: 8];
    endfunction

    function automatic logic [MAT_W-1:0] setEl(logic [MAT_W-1:0] m, int row, int col, logic [7:0] v);
        logic [MAT_W-1:0] r;
        r = m;
        r[MAT_W - 1 - 8 * (ELEMS * row + col) -: 8] = v;
        return r;
    endfunction

    task automatic modelReset();
        for (int r = 0; r < NREGS; r++) mreg[r] = '0;
        mcnt = 0;
    endtask

    task automatic modelExec(input logic [3:0] op, input int rd, input int rs1, input int rs2,
                             input int col, input int imm, input logic [MAT_W-1:0] data);
        logic [MAT_W-1:0] a, b, r;
        logic [7:0]       e;
        a = mreg[rs1];
        b = mreg[rs2];
        r = '0;
        expStore = 1'b0;
        case (op)
            XOR_OP: mreg[rd] = a ^ b;
            ADD_OP, SUB_OP: begin
                for (int i = 0; i < LANES; i++)
                    for (int j = 0; j < ELEMS; j++) begin
                        e = (op == ADD_OP) ? getEl(a, i, j) + getEl(b, i, j)
                                           : getEl(a, i, j) - getEl(b, i, j);
                        r = setEl(r, i, j, e);
                    end
                mreg[rd] = r;
            end
            ROTL_OP: begin
                for (int i = 0; i < LANES; i++)
                    for (int j = 0; j < ELEMS; j++)
                        r = setEl(r, i, j, getEl(a, i, (j + col) % ELEMS));
                mreg[rd] = r;
            end
            TRANS_OP: begin
                for (int i = 0; i < LANES; i++)
                    for (int j = 0; j < ELEMS; j++)
                        r = setEl(r, i, j, getEl(a, j, i));
                mreg[rd] = r;
            end
            LDCNT_OP: mcnt = imm;
            DEC_OP:   if (mcnt > 0) mcnt = mcnt - 1;
            STORE_OP: begin
                expStore     = 1'b1;
                expStoreData = a;
            end
            LOAD_OP:  mreg[rd] = data;
            default: ;
        endcase
    endtask

    task automatic checkOutput(input string tag, input logic [MAT_W-1:0] obs, input logic [MAT_W-1:0] exp);
        testCount++;
        assert (obs === exp) else begin
            failCount++;
            $error("[TB] FAIL %s: observed %0h, expected %0h", tag, obs, exp);
        end
    endtask

    // Offer one instruction, wait (bounded) for acceptance, then return one
    // delay unit after the accepting edge. The model is updated on acceptance.
    task automatic applyStimulus(input logic [3:0] op, input int rd, input int rs1, input int rs2,
                                 input int col, input int imm, input logic [MAT_W-1:0] data,
                                 output int waited);
        @(negedge clk);
        in_valid = 1'b1;
        in_op    = op;
        in_rd    = RA_W'(rd);
        in_rs1   = RA_W'(rs1);
        in_rs2   = RA_W'(rs2);
        in_col   = COL_W'(col);
        in_imm   = CNT_W'(imm);
        in_data  = data;
        waited   = 0;
        while (!in_ready && waited < 20) begin
            @(negedge clk);
            waited++;
        end
        if (!in_ready) begin
            testCount++;
            failCount++;
            $error("[TB] FAIL accept_timeout: observed in_ready 0 for %0d cycles, expected 1", waited);
            in_valid = 1'b0;
            return;
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_op    = 4'd0;
        modelExec(op, rd, rs1, rs2, col, imm, data);
    endtask

    // Check that the store accepted on the previous call appears after one more edge.
    task automatic checkStoreNext(input string tag);
        @(posedge clk);
        #1;
        checkOutput({tag, "_valid"}, MAT_W'(out_valid), MAT_W'(1));
        checkOutput(tag, out_matrix, expStoreData);
    endtask

    initial begin
        logic [MAT_W-1:0] d0, firstData, pendData;
        int   w, totalWait;
        bit   pendStore, pendZero;
        int   op, rdv, r1v, r2v, colv, immv;

        d0 = 128'h01020304_05060708_090A0B0C_0D0E0F10;
        rst = 1'b0; in_valid = 1'b0; in_op = '0; in_rd = '0; in_rs1 = '0; in_rs2 = '0;
        in_col = '0; in_imm = '0; in_data = '0; out_ready = 1'b1;
        modelReset();
        expStore = 1'b0; expStoreData = '0;

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        checkOutput("rst_busy",      MAT_W'(busy),      MAT_W'(0));
        checkOutput("rst_out_valid", MAT_W'(out_valid), MAT_W'(0));
        checkOutput("rst_cnt_zero",  MAT_W'(cnt_zero),  MAT_W'(1));
        checkOutput("rst_in_ready",  MAT_W'(in_ready),  MAT_W'(1));
        checkOutput("rst_out_matrix", out_matrix, '0);
        @(negedge clk);
        rst = 1'b1;

        // Load and store with the exact one-cycle pulse
        applyStimulus(LOAD_OP, 0, 0, 0, 0, 0, d0, w);
        applyStimulus(STORE_OP, 0, 0, 0, 0, 0, '0, w);
        checkOutput("store_not_early", MAT_W'(out_valid), MAT_W'(0));
        checkStoreNext("load_store");
        checkOutput("load_store_const", out_matrix, d0);
        checkOutput("load_store_cnt_zero", MAT_W'(cnt_zero), MAT_W'(1));
        @(posedge clk);
        #1;
        checkOutput("store_pulse_end", MAT_W'(out_valid), MAT_W'(0));

        // Back-to-back dependent instructions resolved by forwarding
        totalWait = 0;
        applyStimulus(LOAD_OP, 1, 0, 0, 0, 0, {16{8'hFF}}, w); totalWait += w;
        applyStimulus(ADD_OP, 2, 1, 1, 0, 0, '0, w);           totalWait += w;
        applyStimulus(STORE_OP, 0, 2, 0, 0, 0, '0, w);         totalWait += w;
        checkStoreNext("fwd_add");
        checkOutput("fwd_add_const", out_matrix, {16{8'hFE}});
        checkOutput("fwd_no_stall", MAT_W'(totalWait), MAT_W'(0));

        // Rotate and transpose
        applyStimulus(ROTL_OP, 1, 0, 0, 1, 0, '0, w);
        applyStimulus(STORE_OP, 0, 1, 0, 0, 0, '0, w);
        checkStoreNext("rotl");
        checkOutput("rotl_row0", MAT_W'(out_matrix[MAT_W-1 -: 32]), MAT_W'(32'h02030401));
        applyStimulus(TRANS_OP, 2, 0, 0, 0, 0, '0, w);
        applyStimulus(STORE_OP, 0, 2, 0, 0, 0, '0, w);
        checkStoreNext("trans");
        checkOutput("trans_row0", MAT_W'(out_matrix[MAT_W-1 -: 32]), MAT_W'(32'h0105090D));

        // Counter load, decrement and saturation
        applyStimulus(LDCNT_OP, 0, 0, 0, 0, 2, '0, w);
        @(posedge clk); #1;
        checkOutput("cnt_ld2", MAT_W'(cnt_zero), MAT_W'(mcnt == 0));
        for (int k = 0; k < 3; k++) begin
            applyStimulus(DEC_OP, 0, 0, 0, 0, 0, '0, w);
            @(posedge clk); #1;
            checkOutput($sformatf("cnt_dec%0d", k), MAT_W'(cnt_zero), MAT_W'(mcnt == 0));
        end
        checkOutput("cnt_dec_last_const", MAT_W'(cnt_zero), MAT_W'(1));

        // Back-pressure on the store port
        out_ready = 1'b0;
        applyStimulus(STORE_OP, 0, 0, 0, 0, 0, '0, w);
        firstData = expStoreData;
        applyStimulus(STORE_OP, 0, 1, 0, 0, 0, '0, w);
        checkOutput("bp_second_accept_wait", MAT_W'(w), MAT_W'(0));
        checkOutput("bp_in_ready_low", MAT_W'(in_ready), MAT_W'(0));
        repeat (3) @(posedge clk);
        #1;
        checkOutput("bp_hold_valid", MAT_W'(out_valid), MAT_W'(1));
        checkOutput("bp_hold_data", out_matrix, firstData);
        checkOutput("bp_hold_in_ready", MAT_W'(in_ready), MAT_W'(0));
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk); #1;
        checkOutput("bp_second_valid", MAT_W'(out_valid), MAT_W'(1));
        checkOutput("bp_second_data", out_matrix, expStoreData);
        checkOutput("bp_released_in_ready", MAT_W'(in_ready), MAT_W'(1));
        @(posedge clk); #1;
        checkOutput("bp_drained", MAT_W'(out_valid), MAT_W'(0));

        // Reset while an ADD sits in S1 and a store is pending
        out_ready = 1'b0;
        applyStimulus(STORE_OP, 0, 0, 0, 0, 0, '0, w);
        applyStimulus(ADD_OP, 3, 0, 1, 0, 0, '0, w);
        checkOutput("mid_busy_before", MAT_W'(busy), MAT_W'(1));
        checkOutput("mid_valid_before", MAT_W'(out_valid), MAT_W'(1));
        #2;
        rst = 1'b0;
        #1;
        checkOutput("mid_rst_busy", MAT_W'(busy), MAT_W'(0));
        checkOutput("mid_rst_out_valid", MAT_W'(out_valid), MAT_W'(0));
        checkOutput("mid_rst_cnt_zero", MAT_W'(cnt_zero), MAT_W'(1));
        modelReset();
        @(negedge clk);
        rst = 1'b1;
        out_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        checkOutput("mid_rst_no_writeback_busy", MAT_W'(busy), MAT_W'(0));
        applyStimulus(STORE_OP, 0, 3, 0, 0, 0, '0, w);
        checkStoreNext("mid_rst_r3");
        checkOutput("mid_rst_r3_zero", out_matrix, '0);
        applyStimulus(LOAD_OP, 0, 0, 0, 0, 0, d0, w);

        // Random back-to-back stream with the store port always ready
        pendStore = 1'b0;
        pendData  = '0;
        pendZero  = (mcnt == 0);
        for (int k = 0; k < 150; k++) begin
            op   = $urandom_range(0, 12);
            if (op > 9) op = (op == 12) ? 15 : ((op == 11) ? STORE_OP : ADD_OP);
            rdv  = $urandom_range(0, NREGS - 1);
            r1v  = $urandom_range(0, NREGS - 1);
            r2v  = $urandom_range(0, NREGS - 1);
            colv = $urandom_range(0, ELEMS - 1);
            immv = $urandom_range(0, 3);
            applyStimulus(4'(op), rdv, r1v, r2v, colv, immv,
                          {$urandom, $urandom, $urandom, $urandom}, w);
            checkOutput("rnd_no_stall", MAT_W'(w), MAT_W'(0));
            checkOutput("rnd_out_valid", MAT_W'(out_valid), MAT_W'(pendStore));
            if (pendStore) checkOutput("rnd_store", out_matrix, pendData);
            checkOutput("rnd_cnt_zero", MAT_W'(cnt_zero), MAT_W'(pendZero));
            pendStore = expStore;
            pendData  = expStoreData;
            pendZero  = (mcnt == 0);
        end
        @(posedge clk); #1;
        checkOutput("rnd_tail_valid", MAT_W'(out_valid), MAT_W'(pendStore));
        if (pendStore) checkOutput("rnd_tail_store", out_matrix, pendData);
        checkOutput("rnd_tail_cnt_zero", MAT_W'(cnt_zero), MAT_W'(pendZero));

        $display("[TB] %0d tests run, %0d failed", testCount, failCount);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: observed no completion, expected finish before time limit");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
